multi_pwm_gen: RTL and testbench
================================

Name: multi_pwm_gen

Overview:
Parametrised N-channel PWM generator for the photonic-switch drivers, running entirely on clkCore. A shared period counter drives per-channel rise/fall comparators and set/reset-dominant level registers, with complementary outputs separated by a programmable dead time. Per-channel timing is written through a simple write port and stays staged until the period boundary, so a frame never mixes old and new settings. The block supersedes the two-clock, single-channel generator in the switch controller.

Parameters:
N_CH, 4, number of PWM channels (1..16)
W, 7, width of the period counter and of all timing values
DEAD_W, 4, width of the dead-time value

Ports:
clkCore  in  1  core clock; every flop is on the rising edge
reset_b  in  1  asynchronous active-low reset
en  in  1  global run enable
period_val  in  W  period length in clkCore cycles; sampled at commit
dead_val  in  DEAD_W  dead-time cycles; sampled at commit
cfg_we  in  1  write strobe for the staging registers
cfg_ch  in  clog2(N_CH) (min 1)  channel select for a write
cfg_rise  in  W  count value at which the channel sets
cfg_fall  in  W  count value at which the channel resets
cfg_pending  out  1  high from a staged write until it is committed
frame_start  out  1  one-cycle pulse when cnt wraps to 0
cnt  out  W  current period count
pwm  out  N_CH  main drive outputs
pwm_b  out  N_CH  complementary drive outputs

Behaviour:
- Reset (reset_b=0, async):
  - cnt=0; all levels, pwm and pwm_b are 0.
  - Committed and staged rise/fall registers are all 0.
  - Committed period=0 and dead=0; cfg_pending=0; frame_start=0.
- Staging:
  - When cfg_we=1 and cfg_ch<N_CH, store cfg_rise/cfg_fall into the staging pair for that channel and set cfg_pending.
  - A write with cfg_ch>=N_CH is ignored.
  - A later write to the same channel before commit overwrites the earlier one.
- Commit: copy all staging pairs, period_val and dead_val into the committed registers, and clear cfg_pending, when either:
  - the edge moves cnt from period-1 to 0 (wrap), or
  - on every cycle while en=0 or the committed period is 0.
- A cfg_we on the commit edge lands in staging only and is committed at the next boundary.
- Counter:
  - Runs only when en=1 and the committed period is non-zero.
  - Increments each cycle; wraps from period-1 to 0.
  - frame_start=1 in the cycle where cnt==0 after a wrap. No pulse on the first cycle after enable.
  - en=0 holds cnt at 0.
- Channel level (per channel, registered), evaluated on each edge while running:
  - If cnt==fall: lvl becomes 0. Fall wins, so rise==fall means the channel stays low.
  - Else if cnt==rise: lvl becomes 1.
  - A rise or fall value >= period never matches, so its edge never happens.
  - The level changes in the cycle after cnt shows the matching value (latency 1).
- Dead time (per channel):
  - A counter dc reloads to 0 on every lvl change and saturates at dead.
  - pwm = lvl AND (dc>=dead); pwm_b = NOT lvl AND (dc>=dead).
  - With dead=0, pwm=lvl and pwm_b=NOT lvl, with no gap.
  - pwm and pwm_b are never high together.
- en=0 (or committed period 0):
  - Levels are forced to 0, pwm=0 and pwm_b=0 (safe state).
  - On re-enable, dc starts at 0, so pwm_b rises after dead cycles.
- Reset mid-frame clears everything immediately; no partial frame is completed.

Decomposition:
- Package pwm_pkg holds:
  - the W/DEAD_W/N_CH defaults;
  - a chan_cfg_t typedef for the rise/fall pair;
  - the SAFE output constant (all zeros).
- One sub-module, pwm_channel, covers the comparators, the fall-dominant level register and the dead-time counter/gating. Instantiate it N_CH times with a generate loop.
- The top level owns the counter, the staging/commit logic and the write decode.

Test Plan:
- Basic waveform:
  - Stimulus: reset; write ch0 rise=2, fall=6; period=10, dead=0; en=1.
  - Response: pwm[0] is high while cnt is 3..6 (lvl lags the match by one cycle), low otherwise; pwm_b[0] is its inverse; frame_start pulses every 10 cycles.
- Dead time:
  - Stimulus: same as above with dead=2.
  - Response: pwm[0] high while cnt is 5..6; pwm_b[0] low while cnt is 3..4 and 7..8; they never overlap.
- Glitch-free update:
  - Stimulus: mid-frame, write ch0 fall=8.
  - Response: the current frame still falls at 6; cfg_pending=1 until the wrap; the next frame falls at 8.
- Boundary values:
  - rise=fall=4: output is constantly low.
  - rise=12 with period=10: the channel never sets.
  - cfg_ch=N_CH: no state change.
- Enable and reset mid-operation:
  - Drop en mid-frame: the next cycle has pwm=0 and pwm_b=0, and cnt returns to 0.
  - Assert reset_b=0 asynchronously between clock edges: all outputs clear before the next edge.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared defaults, the per-channel rise/fall pair and the safe output level
// used by every multi_pwm_gen file.
package pwm_pkg;
    localparam int N_CH_DEF   = 4;
    localparam int W_DEF      = 7;
    localparam int DEAD_W_DEF = 4;
    // Storage width of a rise/fall pair; W must not exceed this.
    localparam int W_MAX      = 16;

    typedef struct packed {
        logic [W_MAX-1:0] rise;
        logic [W_MAX-1:0] fall;
    } chan_cfg_t;

    // Level every drive output takes while the generator is idle.
    localparam logic SAFE_LVL = 1'b0;
endpackage

// File: rtl/multi_pwm_gen_if.sv
// Channel timing write port: strobe, channel select, rise/fall values and the
// pending flag returned by the generator.
interface multi_pwm_gen_if #(
    parameter int N_CH = 4,
    parameter int W    = 7
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic            cfg_we;
    logic [CH_W-1:0] cfg_ch;
    logic [W-1:0]    cfg_rise;
    logic [W-1:0]    cfg_fall;
    logic            cfg_pending;

    modport master (output cfg_we, cfg_ch, cfg_rise, cfg_fall, input cfg_pending);
    modport slave  (input cfg_we, cfg_ch, cfg_rise, cfg_fall, output cfg_pending);
endinterface

// File: rtl/pwm_channel.sv
// One PWM channel: rise/fall comparators, fall-dominant level register and
// dead-time counter gating the complementary outputs.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int DEAD_W = DEAD_W_DEF
) (
    input  logic              clkCore,
    input  logic              reset_b,
    input  logic              run,     // counter advances on this edge
    input  logic              active,  // counter was running last edge
    input  logic [W-1:0]      cnt,
    input  logic [W-1:0]      period,
    input  logic [DEAD_W-1:0] dead,
    input  chan_cfg_t         cfg,
    output logic              pwm,
    output logic              pwm_b
);
    logic              lvl_q, lvl_d;
    logic [DEAD_W-1:0] dc_q, dc_d;
    logic              rise_hit, fall_hit, gate;

    // Next level and dead-time count; values at or beyond the period never match.
    always_comb begin
        rise_hit = (W_MAX'(cnt) == cfg.rise) && (cfg.rise < W_MAX'(period));
        fall_hit = (W_MAX'(cnt) == cfg.fall) && (cfg.fall < W_MAX'(period));
        lvl_d = lvl_q;
        if (!run)          lvl_d = 1'b0;
        else if (fall_hit) lvl_d = 1'b0;
        else if (rise_hit) lvl_d = 1'b1;
        dc_d = dc_q;
        // Restart the gap on any level change and on the first running cycle.
        if (!run || !active || (lvl_d != lvl_q)) dc_d = '0;
        else if (dc_q < dead)                     dc_d = dc_q + DEAD_W'(1);
    end

    // Level and dead-time counter registers.
    always_ff @(posedge clkCore or negedge reset_b) begin
        if (!reset_b) begin
            lvl_q <= 1'b0;
            dc_q  <= '0;
        end else begin
            lvl_q <= lvl_d;
            dc_q  <= dc_d;
        end
    end

    // Gated complementary drive; both low while idle.
    always_comb begin
        gate  = (dc_q >= dead);
        pwm   = active ? (lvl_q & gate)  : SAFE_LVL;
        pwm_b = active ? (~lvl_q & gate) : SAFE_LVL;
    end
endmodule

// File: rtl/multi_pwm_gen.sv
// N-channel PWM generator: shared period counter, staged channel timing that
// commits only at the period boundary (or whenever idle), per-channel drivers.
module multi_pwm_gen
    import pwm_pkg::*;
#(
    parameter int N_CH   = N_CH_DEF,
    parameter int W      = W_DEF,
    parameter int DEAD_W = DEAD_W_DEF
) (
    input  logic              clkCore,
    input  logic              reset_b,
    input  logic              en,
    input  logic [W-1:0]      period_val,
    input  logic [DEAD_W-1:0] dead_val,
    multi_pwm_gen_if.slave    cfg,
    output logic              frame_start,
    output logic [W-1:0]      cnt,
    output logic [N_CH-1:0]   pwm,
    output logic [N_CH-1:0]   pwm_b
);
    logic [W-1:0]      cnt_q, cnt_d, period_q, period_d;
    logic [DEAD_W-1:0] dead_q, dead_d;
    logic              fs_q, fs_d, run_q, pending_q, pending_d;
    chan_cfg_t         act_q [N_CH];
    chan_cfg_t         act_d [N_CH];
    chan_cfg_t         stg_q [N_CH];
    chan_cfg_t         stg_d [N_CH];
    logic              run, wrap, commit, wr_ok;

    // Counter, commit decision and write decode.
    always_comb begin
        run       = en && (period_q != '0);
        wrap      = run && (cnt_q == period_q - W'(1));
        commit    = wrap || !run;
        cnt_d     = (run && !wrap) ? cnt_q + W'(1) : '0;
        fs_d      = wrap;
        wr_ok     = cfg.cfg_we && (32'(cfg.cfg_ch) < N_CH);
        // Commit copies the pre-edge staging, so a write on this edge waits.
        act_d     = commit ? stg_q : act_q;
        period_d  = commit ? period_val : period_q;
        dead_d    = commit ? dead_val : dead_q;
        stg_d     = stg_q;
        if (wr_ok) stg_d[cfg.cfg_ch] = '{rise: W_MAX'(cfg.cfg_rise), fall: W_MAX'(cfg.cfg_fall)};
        pending_d = wr_ok ? 1'b1 : (commit ? 1'b0 : pending_q);
    end

    // Counter, committed and staged configuration registers.
    always_ff @(posedge clkCore or negedge reset_b) begin
        if (!reset_b) begin
            cnt_q     <= '0;
            period_q  <= '0;
            dead_q    <= '0;
            fs_q      <= 1'b0;
            run_q     <= 1'b0;
            pending_q <= 1'b0;
            act_q     <= '{default: '0};
            stg_q     <= '{default: '0};
        end else begin
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            dead_q    <= dead_d;
            fs_q      <= fs_d;
            run_q     <= run;
            pending_q <= pending_d;
            act_q     <= act_d;
            stg_q     <= stg_d;
        end
    end

    assign cnt             = cnt_q;
    assign frame_start     = fs_q;
    assign cfg.cfg_pending = pending_q;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        pwm_channel #(.W(W), .DEAD_W(DEAD_W)) u_ch (
            .clkCore (clkCore),
            .reset_b (reset_b),
            .run     (run),
            .active  (run_q),
            .cnt     (cnt_q),
            .period  (period_q),
            .dead    (dead_q),
            .cfg     (act_q[g]),
            .pwm     (pwm[g]),
            .pwm_b   (pwm_b[g])
        );
    end
endmodule

// File: tb/tb_multi_pwm_gen.sv
// Randomized and directed bench for multi_pwm_gen against a cycle model.
module tb_multi_pwm_gen;
    localparam int N      = 3;   // non power of two so an out-of-range channel exists
    localparam int W      = 7;
    localparam int DEAD_W = 4;

    logic              clkCore, reset_b, en;
    logic [W-1:0]      period_val;
    logic [DEAD_W-1:0] dead_val;
    logic              frame_start;
    logic [W-1:0]      cnt;
    logic [N-1:0]      pwm, pwm_b;

    multi_pwm_gen_if #(.N_CH(N), .W(W)) cfg_if ();

    multi_pwm_gen #(.N_CH(N), .W(W), .DEAD_W(DEAD_W)) dut (
        .clkCore     (clkCore),
        .reset_b     (reset_b),
        .en          (en),
        .period_val  (period_val),
        .dead_val    (dead_val),
        .cfg         (cfg_if),
        .frame_start (frame_start),
        .cnt         (cnt),
        .pwm         (pwm),
        .pwm_b       (pwm_b)
    );

    initial clkCore = 1'b0;
    always #5 clkCore = ~clkCore;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: frame position, committed/staged timing, per channel
    // level and dead-time count, all as plain integers.
    int m_cnt, m_per, m_dead, m_fs, m_pend, m_act;
    int m_rise [N], m_fall [N], s_rise [N], s_fall [N], m_lvl [N], m_dc [N];

    task automatic model_reset();
        m_cnt = 0; m_per = 0; m_dead = 0; m_fs = 0; m_pend = 0; m_act = 0;
        for (int i = 0; i < N; i++) begin
            m_rise[i] = 0; m_fall[i] = 0; s_rise[i] = 0; s_fall[i] = 0;
            m_lvl[i] = 0; m_dc[i] = 0;
        end
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_edge();
        bit running, wrapping, upd, wr;
        int nl;
        running  = en && (m_per != 0);
        wrapping = running && (m_cnt == m_per - 1);
        upd      = wrapping || !running;
        wr       = cfg_if.cfg_we && (int'(cfg_if.cfg_ch) < N);
        for (int i = 0; i < N; i++) begin
            if (!running) nl = 0;
            else if (m_cnt == m_fall[i] && m_fall[i] < m_per) nl = 0;
            else if (m_cnt == m_rise[i] && m_rise[i] < m_per) nl = 1;
            else nl = m_lvl[i];
            if (!running || !m_act || nl != m_lvl[i]) m_dc[i] = 0;
            else if (m_dc[i] < m_dead) m_dc[i]++;
            m_lvl[i] = nl;
        end
        m_cnt = (running && !wrapping) ? m_cnt + 1 : 0;
        m_fs  = wrapping;
        m_act = running;
        if (upd) begin
            m_per  = int'(period_val);
            m_dead = int'(dead_val);
            for (int i = 0; i < N; i++) begin
                m_rise[i] = s_rise[i]; m_fall[i] = s_fall[i];
            end
        end
        if (wr) begin
            s_rise[cfg_if.cfg_ch] = int'(cfg_if.cfg_rise);
            s_fall[cfg_if.cfg_ch] = int'(cfg_if.cfg_fall);
            m_pend = 1;
        end else if (upd) begin
            m_pend = 0;
        end
    endtask

    function automatic logic [N-1:0] exp_out(input bit inv);
        logic [N-1:0] v;
        for (int i = 0; i < N; i++)
            v[i] = m_act && (m_dc[i] >= m_dead) && (inv ? (m_lvl[i] == 0) : (m_lvl[i] == 1));
        return v;
    endfunction

    task automatic step();
        model_edge();
        @(posedge clkCore);
        #1;
        chk("cnt", cnt, m_cnt);
        chk("frame_start", frame_start, m_fs);
        chk("cfg_pending", cfg_if.cfg_pending, m_pend);
        chk("pwm", pwm, exp_out(0));
        chk("pwm_b", pwm_b, exp_out(1));
        chk("overlap", pwm & pwm_b, 0);
    endtask

    task automatic drive(input bit e, input bit we, input int ch, input int r, input int f,
                         input int per, input int dd);
        en              = e;
        cfg_if.cfg_we   = we;
        cfg_if.cfg_ch   = 2'(ch);
        cfg_if.cfg_rise = W'(r);
        cfg_if.cfg_fall = W'(f);
        period_val      = W'(per);
        dead_val        = DEAD_W'(dd);
    endtask

    int hi0, hib0, hi1, hi2, hib1, nfs;

    initial begin
        reset_b = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #2;
        chk("rst_cnt", cnt, 0);
        chk("rst_pwm", pwm, 0);
        chk("rst_pwm_b", pwm_b, 0);
        chk("rst_fs", frame_start, 0);
        chk("rst_pend", cfg_if.cfg_pending, 0);
        @(posedge clkCore); #1;
        reset_b = 1'b1;

        // Basic waveform: ch0 rise=2 fall=6, period 10, no dead time.
        drive(0, 1, 0, 2, 6, 10, 0); step();
        drive(0, 0, 0, 0, 0, 10, 0); step();
        en = 1'b1;
        hi0 = 0; hib0 = 0; nfs = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            hi0 += int'(pwm[0]); hib0 += int'(pwm_b[0]); nfs += int'(frame_start);
        end
        chk("basic_pwm_hi", hi0, 8);
        chk("basic_pwmb_hi", hib0, 12);
        chk("basic_fs", nfs, 2);

        // Dead time 2: measure the second (steady) frame.
        drive(0, 0, 0, 0, 0, 10, 2); step();
        en = 1'b1;
        hi0 = 0; hib0 = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (k >= 10) begin hi0 += int'(pwm[0]); hib0 += int'(pwm_b[0]); end
        end
        chk("dead_pwm_hi", hi0, 2);
        chk("dead_pwmb_hi", hib0, 4);

        // Glitch-free update: move fall to 8 mid-frame.
        step(); step();
        drive(1, 1, 0, 2, 8, 10, 2); step();
        chk("glitch_pend", cfg_if.cfg_pending, 1);
        drive(1, 0, 0, 0, 0, 10, 2);
        hi0 = 0;
        for (int k = 0; k < 7; k++) begin step(); hi0 += int'(pwm[0]); end
        chk("glitch_old", hi0, 2);
        hi0 = 0;
        for (int k = 0; k < 10; k++) begin step(); hi0 += int'(pwm[0]); end
        chk("glitch_new", hi0, 4);

        // Boundaries: rise==fall, rise beyond period, out-of-range channel.
        drive(0, 1, 1, 4, 4, 10, 0); step();
        drive(0, 1, 2, 12, 3, 10, 0); step();
        drive(1, 0, 0, 0, 0, 10, 0);
        hi1 = 0; hi2 = 0; hib1 = 0;
        for (int k = 0; k < 20; k++) begin
            step(); hi1 += int'(pwm[1]); hi2 += int'(pwm[2]); hib1 += int'(pwm_b[1]);
        end
        chk("bnd_eq_hi", hi1, 0);
        chk("bnd_eq_b", hib1, 20);
        chk("bnd_big_hi", hi2, 0);
        drive(1, 1, 3, 1, 5, 10, 0); step();
        chk("bnd_badch_pend", cfg_if.cfg_pending, 0);
        drive(1, 0, 0, 0, 0, 10, 0);
        for (int k = 0; k < 10; k++) step();

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            drive(($urandom % 20) != 0, ($urandom % 4) == 0, $urandom % 4,
                  $urandom % 24, $urandom % 24,
                  (($urandom % 10) == 0) ? 0 : 3 + ($urandom % 15), $urandom % 4);
            step();
        end

        // Drop enable mid-frame.
        drive(1, 0, 0, 0, 0, 10, 1);
        for (int k = 0; k < 8; k++) step();
        en = 1'b0; step();
        chk("endrop_cnt", cnt, 0);
        chk("endrop_pwm", pwm, 0);
        chk("endrop_pwm_b", pwm_b, 0);

        // Asynchronous reset between edges.
        drive(1, 0, 0, 0, 0, 10, 1);
        for (int k = 0; k < 6; k++) step();
        #2;
        reset_b = 1'b0;
        #1;
        chk("arst_cnt", cnt, 0);
        chk("arst_pwm", pwm, 0);
        chk("arst_pwm_b", pwm_b, 0);
        chk("arst_fs", frame_start, 0);
        chk("arst_pend", cfg_if.cfg_pending, 0);
        model_reset();
        @(posedge clkCore); #1;
        reset_b = 1'b1;
        for (int k = 0; k < 15; k++) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
